// File: rtl/sgpr_restore_ctrl.sv
// rtl/sgpr_restore_ctrl.sv - halts both cores and copies the shared GPR into both private register files
// Optional restore counter output restore_cnt_o enabled by macro SGPR_RESTORE_CNT_EN.
module sgpr_restore_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter bit SKIP_R0  = 1'b1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mismatch_i,
    input  logic              start_i,
    output logic              halt_o,
    input  logic              halt_ack_i,
    output logic [AW-1:0]     raddr_o,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              we_o,
    output logic [AW-1:0]     waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              busy_o,
    output logic              done_o
`ifdef SGPR_RESTORE_CNT_EN
    ,
    output logic [7:0]        restore_cnt_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_HALT, S_COPY, S_DONE} state_t;

    localparam logic [AW-1:0] FIRST = SKIP_R0 ? AW'(1) : AW'(0);
    localparam logic [AW-1:0] LAST  = AW'(NUM_REGS - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          pending_q, pending_d;
    logic          trig;

    assign trig = mismatch_i | start_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pending_d = pending_q;
        case (state_q)
            S_IDLE: begin
                // a trigger that landed in DONE on its way out is replayed from here
                if (trig || pending_q) begin
                    state_d   = S_HALT;
                    pending_d = 1'b0;
                end
            end
            S_HALT: begin
                if (trig) pending_d = 1'b1;
                if (halt_ack_i) begin
                    state_d = S_COPY;
                    addr_d  = FIRST;
                end
            end
            S_COPY: begin
                if (trig) pending_d = 1'b1;
                if (addr_q == LAST) state_d = S_DONE;
                else                addr_d  = addr_q + AW'(1);
            end
            S_DONE: begin
                // the restore starting now covers any trigger arriving this cycle
                if (pending_q) begin
                    state_d   = S_HALT;
                    pending_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                    if (trig) pending_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pending_q <= pending_d;
        end
    end

    // outputs decode the state flop directly so reset removes them without waiting for a clock
    assign busy_o  = (state_q != S_IDLE);
    assign halt_o  = busy_o;
    assign we_o    = (state_q == S_COPY);
    assign done_o  = (state_q == S_DONE);
    assign raddr_o = busy_o ? addr_q : '0;
    assign waddr_o = busy_o ? addr_q : '0;
    assign wdata_o = we_o ? rdata_i : '0;

`ifdef SGPR_RESTORE_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_DONE && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 8'd0;
        else        cnt_q <= cnt_d;
    end

    assign restore_cnt_o = cnt_q;
`endif

endmodule
